// File: rtl/mips_wb_pkg.sv
// mips_wb_pkg: shared types for the writeback write sequencer.
// Holds the register index type, the queued write request, and the
// write-source selector used by the output arbitration.
package mips_wb_pkg;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t    rd;
    logic [31:0] data;
  } wb_req_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  // Which source loads the output register on the coming edge.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_FIFO = 2'd2,
    SRC_BYP  = 2'd3
  } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous circular FIFO of wb_req_t entries for the load path.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module wb_fifo
  import mips_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t push_req,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  wb_req_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign head   = r_mem[r_rd_ptr];

  // Pointer and occupancy tracking; push and pop together leave the count unchanged.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage, written on an accepted push.
  // NOTE: the storage array is deliberately not reset; r_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_req;
  end

endmodule

// File: rtl/wb_write_sequencer.sv
// wb_write_sequencer: writeback driver of the register-file write port.
// Merges the ALU path (highest priority, never stalls) with buffered load
// results into one registered write per cycle, and keeps a per-register
// count of outstanding loads that drives the pending vector for decode.
// Optional feature: define WB_BYPASS_EN to let a load arriving with the
// FIFO empty and the ALU idle go straight to the output register.
module wb_write_sequencer
  import mips_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_ready,
  output logic        wren,
  output logic [4:0]  wr,
  output logic [31:0] wd,
  output logic [31:0] pending,
  output logic        busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                   w_full;
  logic                   w_empty;
  wb_req_t                w_head;
  wb_req_t                w_ld_req;
  logic                   w_ld_acc;
  logic                   w_push;
  logic                   w_pop;
  wb_src_t                w_src;
  wb_req_t                w_sel;
  logic                   w_ld_write;
  logic                   w_iss_fire;
  logic [31:0][CNT_W-1:0] w_cnt;

  logic        r_wren;
  logic [4:0]  r_wr;
  logic [31:0] r_wd;

  // Ready is taken from the registered occupancy, so a full FIFO refuses
  // a load even on an edge where the head is draining.
  assign ld_ready = !w_full;
  assign busy     = !w_empty;
  assign w_ld_req = '{rd: ld_rd, data: ld_data};
  assign w_ld_acc = ld_valid && ld_ready && (ld_rd != REG_ZERO);

  assign iss_ready  = (iss_rd == REG_ZERO) || (w_cnt[iss_rd] != CNT_MAX);
  assign w_iss_fire = iss_valid && iss_ready && (iss_rd != REG_ZERO);

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .push_req (w_ld_req),
    .pop      (w_pop),
    .full     (w_full),
    .empty    (w_empty),
    .head     (w_head)
  );

  // Write-source arbitration: ALU first, then FIFO head, then (optionally) bypass.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_src = SRC_NONE;
    w_sel = '0;
    if (alu_valid) begin
      // A valid ALU op to r0 still owns the slot; it simply writes nothing.
      if (alu_rd != REG_ZERO) begin
        w_src = SRC_ALU;
        w_sel = '{rd: alu_rd, data: alu_data};
      end
    end else if (!w_empty) begin
      w_src = SRC_FIFO;
      w_sel = w_head;
    end
`ifdef WB_BYPASS_EN
    else if (w_ld_acc) begin
      w_src = SRC_BYP;
      w_sel = w_ld_req;
    end
`endif
  end

  assign w_pop      = (w_src == SRC_FIFO);
  assign w_push     = w_ld_acc && (w_src != SRC_BYP);
  assign w_ld_write = (w_src == SRC_FIFO) || (w_src == SRC_BYP);

  // Output register; wr/wd hold their last values on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wren <= 1'b0;
      r_wr   <= REG_ZERO;
      r_wd   <= '0;
    end else begin
      r_wren <= (w_src != SRC_NONE);
      if (w_src != SRC_NONE) begin
        r_wr <= w_sel.rd;
        r_wd <= w_sel.data;
      end
    end
  end

  assign wren = r_wren;
  assign wr   = r_wr;
  assign wd   = r_wd;

  // Register 0 never has an outstanding load.
  assign w_cnt[0]   = '0;
  assign pending[0] = 1'b0;

  for (genvar g = 1; g < 32; g++) begin : g_sb
    logic [CNT_W-1:0] r_cnt;
    logic             w_inc;
    logic             w_dec;

    assign w_inc = w_iss_fire && (iss_rd == reg_idx_t'(g));
    assign w_dec = w_ld_write && (w_sel.rd == reg_idx_t'(g));

    // Outstanding-load counter; an issue and a retire on the same edge cancel.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (w_inc && !w_dec) begin
        r_cnt <= r_cnt + CNT_ONE;
      end else if (w_dec && !w_inc) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end

    assign w_cnt[g]   = r_cnt;
    assign pending[g] = |r_cnt;
  end

endmodule

// File: tb/tb_wb_write_sequencer.sv
// tb_wb_write_sequencer: directed scenarios plus a randomized run checked
// against a queue-based reference model of the writeback sequencer.
// Expectations follow WB_BYPASS_EN when it is defined for the build.
module tb_wb_write_sequencer;
  import mips_wb_pkg::*;

  localparam int DEPTH   = 4;
  localparam int CNT_MAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        wren;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic [31:0] pending;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_write_sequencer #(
    .DEPTH (DEPTH),
    .CNT_W (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .wren      (wren),
    .wr        (wr),
    .wd        (wd),
    .pending   (pending),
    .busy      (busy)
  );

  // ---------------- reference model ----------------
  wb_req_t     m_q[$];
  int          m_cnt[32];
  int          m_unsent[32];
  logic        m_wren;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  function automatic void model_reset();
    m_q.delete();
    for (int i = 0; i < 32; i++) begin
      m_cnt[i]    = 0;
      m_unsent[i] = 0;
    end
    m_wren = 1'b0;
    m_wr   = 5'd0;
    m_wd   = 32'd0;
  endfunction

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    for (int i = 1; i < 32; i++) p[i] = (m_cnt[i] != 0);
    return p;
  endfunction

  function automatic logic model_iss_ready();
    return (iss_rd == 5'd0) || (m_cnt[iss_rd] < CNT_MAX);
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_edge();
    bit      acc;
    bit      inc;
    bit      bypassed;
    wb_req_t e;
    if (rst) begin
      model_reset();
      return;
    end
    acc      = ld_valid && (m_q.size() < DEPTH) && (ld_rd != 5'd0);
    inc      = iss_valid && (iss_rd != 5'd0) && (m_cnt[iss_rd] < CNT_MAX);
    bypassed = 1'b0;
    if (alu_valid) begin
      m_wren = (alu_rd != 5'd0);
      if (alu_rd != 5'd0) begin
        m_wr = alu_rd;
        m_wd = alu_data;
      end
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_wren = 1'b1;
      m_wr   = e.rd;
      m_wd   = e.data;
      m_cnt[e.rd]--;
    end
`ifdef WB_BYPASS_EN
    else if (acc) begin
      m_wren = 1'b1;
      m_wr   = ld_rd;
      m_wd   = ld_data;
      m_cnt[ld_rd]--;
      bypassed = 1'b1;
    end
`endif
    else begin
      m_wren = 1'b0;
    end
    if (acc) begin
      m_unsent[ld_rd]--;
      if (!bypassed) m_q.push_back('{rd: ld_rd, data: ld_data});
    end
    if (inc) begin
      m_cnt[iss_rd]++;
      m_unsent[iss_rd]++;
    end
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    ld_valid  = 1'b0;
    ld_rd     = '0;
    ld_data   = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    rst = 1'b1;
    model_reset();
    #3;
    checks++;
    if (wren !== 1'b0 || wr !== 5'd0 || wd !== 32'd0 || pending !== 32'd0 ||
        busy !== 1'b0 || ld_ready !== 1'b1 || iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: wren=%b wr=%0d wd=%h pending=%h busy=%b ld_ready=%b iss_ready=%b, want 0 0 0 0 0 1 1",
               wren, wr, wd, pending, busy, ld_ready, iss_ready);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_alu();
    idle();
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'hDEADBEEF;
    step();
    idle();
    checks++;
    if (wren !== 1'b1 || wr !== 5'd5 || wd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alu_write: wren=%b wr=%0d wd=%h, want 1 5 deadbeef", wren, wr, wd);
    end
    step();
    checks++;
    if (wren !== 1'b0 || wr !== 5'd5 || wd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alu_hold: wren=%b wr=%0d wd=%h, want 0 5 deadbeef", wren, wr, wd);
    end
  endtask

  task automatic test_load_pending();
    idle();
    iss_valid = 1'b1;
    iss_rd    = 5'd8;
    step();
    idle();
    checks++;
    if (pending !== 32'h0000_0100) begin
      errors++;
      $display("FAIL issue_pending: pending=%h, want 00000100", pending);
    end
    ld_valid = 1'b1;
    ld_rd    = 5'd8;
    ld_data  = 32'h1234;
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready: ld_ready=%b, want 1", ld_ready);
    end
    step();
    idle();
`ifndef WB_BYPASS_EN
    checks++;
    if (wren !== 1'b0 || pending[8] !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_queued: wren=%b pending8=%b busy=%b, want 0 1 1", wren, pending[8], busy);
    end
    step();
`endif
    checks++;
    if (wren !== 1'b1 || wr !== 5'd8 || wd !== 32'h1234 || pending !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load_write: wren=%b wr=%0d wd=%h pending=%h busy=%b, want 1 8 1234 0 0",
               wren, wr, wd, pending, busy);
    end
    step();
    checks++;
    if (wren !== 1'b0) begin
      errors++;
      $display("FAIL load_single: wren=%b, want 0", wren);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    for (int i = 0; i < 4; i++) begin
      iss_valid = 1'b1;
      iss_rd    = 5'(10 + i);
      step();
    end
    idle();
    alu_valid = 1'b1;
    alu_rd    = 5'd1;
    alu_data  = 32'h5555_0001;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_rd    = 5'(10 + i);
      ld_data  = 32'hA000 + 32'(i);
      checks++;
      if (ld_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready[%0d]: ld_ready=%b, want 1", i, ld_ready);
      end
      step();
    end
    checks++;
    if (ld_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fifo_full: ld_ready=%b busy=%b, want 0 1", ld_ready, busy);
    end
    ld_rd   = 5'd14;
    ld_data = 32'hBAD;
    step();
    checks++;
    if (ld_ready !== 1'b0 || wren !== 1'b1 || wr !== 5'd1) begin
      errors++;
      $display("FAIL fifo_stall: ld_ready=%b wren=%b wr=%0d, want 0 1 1", ld_ready, wren, wr);
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (wren !== 1'b1 || wr !== 5'(10 + i) || wd !== 32'hA000 + 32'(i)) begin
        errors++;
        $display("FAIL drain_order[%0d]: wren=%b wr=%0d wd=%h, want 1 %0d %h",
                 i, wren, wr, wd, 10 + i, 32'hA000 + 32'(i));
      end
    end
    step();
    checks++;
    if (wren !== 1'b0 || busy !== 1'b0 || pending !== 32'd0) begin
      errors++;
      $display("FAIL drain_done: wren=%b busy=%b pending=%h, want 0 0 0", wren, busy, pending);
    end
  endtask

  task automatic test_zero_rd();
    idle();
    for (int i = 0; i < 4; i++) begin
      alu_valid = (i < 3);
      alu_rd    = 5'd0;
      alu_data  = 32'hFFFF_0000 + 32'(i);
      ld_valid  = 1'b1;
      ld_rd     = 5'd0;
      ld_data   = 32'h0BAD_0000 + 32'(i);
      step();
      checks++;
      if (wren !== 1'b0 || busy !== 1'b0 || ld_ready !== 1'b1) begin
        errors++;
        $display("FAIL zero_rd[%0d]: wren=%b busy=%b ld_ready=%b, want 0 0 1", i, wren, busy, ld_ready);
      end
    end
    idle();
    step();
    checks++;
    if (wren !== 1'b0) begin
      errors++;
      $display("FAIL zero_rd_after: wren=%b, want 0", wren);
    end
  endtask

  // Delivers one load to r3; optionally issues r3 on the edge the load retires.
  task automatic load_r3(input logic [31:0] data, input bit concurrent_issue);
    idle();
    ld_valid = 1'b1;
    ld_rd    = 5'd3;
    ld_data  = data;
`ifdef WB_BYPASS_EN
    iss_valid = concurrent_issue;
    iss_rd    = 5'd3;
    step();
`else
    step();
    idle();
    iss_valid = concurrent_issue;
    iss_rd    = 5'd3;
    step();
`endif
    idle();
    iss_rd = 5'd3;
  endtask

  task automatic test_saturation();
    idle();
    for (int i = 0; i < 3; i++) begin
      iss_valid = 1'b1;
      iss_rd    = 5'd3;
      checks++;
      if (iss_ready !== 1'b1) begin
        errors++;
        $display("FAIL sat_issue[%0d]: iss_ready=%b, want 1", i, iss_ready);
      end
      step();
    end
    checks++;
    if (iss_ready !== 1'b0 || pending[3] !== 1'b1) begin
      errors++;
      $display("FAIL sat_full: iss_ready=%b pending3=%b, want 0 1", iss_ready, pending[3]);
    end
    step();
    idle();
    load_r3(32'h31, 1'b0);
    checks++;
    if (wren !== 1'b1 || wr !== 5'd3 || wd !== 32'h31 || iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL sat_retire: wren=%b wr=%0d wd=%h iss_ready=%b, want 1 3 31 1", wren, wr, wd, iss_ready);
    end
    load_r3(32'h32, 1'b1);
    checks++;
    if (wren !== 1'b1 || wr !== 5'd3 || wd !== 32'h32 || iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL sat_concurrent: wren=%b wr=%0d wd=%h iss_ready=%b, want 1 3 32 1", wren, wr, wd, iss_ready);
    end
    iss_valid = 1'b1;
    step();
    idle();
    iss_rd = 5'd3;
    checks++;
    if (iss_ready !== 1'b0) begin
      errors++;
      $display("FAIL sat_refill: iss_ready=%b, want 0", iss_ready);
    end
    for (int i = 0; i < 3; i++) begin
      load_r3(32'h40 + 32'(i), 1'b0);
      checks++;
      if (wr !== 5'd3 || wd !== 32'h40 + 32'(i) || pending[3] !== (i < 2)) begin
        errors++;
        $display("FAIL sat_drain[%0d]: wr=%0d wd=%h pending3=%b, want 3 %h %b",
                 i, wr, wd, pending[3], 32'h40 + 32'(i), (i < 2));
      end
    end
  endtask

  task automatic test_reset_midop();
    idle();
    for (int i = 0; i < 3; i++) begin
      iss_valid = 1'b1;
      iss_rd    = 5'(20 + i);
      step();
    end
    idle();
    alu_valid = 1'b1;
    alu_rd    = 5'd2;
    alu_data  = 32'h2222;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_rd    = 5'(20 + i);
      ld_data  = 32'hC000 + 32'(i);
      step();
    end
    checks++;
    if (busy !== 1'b1 || pending !== 32'h0070_0000) begin
      errors++;
      $display("FAIL midop_loaded: busy=%b pending=%h, want 1 00700000", busy, pending);
    end
    rst = 1'b1;
    #2;
    checks++;
    if (busy !== 1'b0 || pending !== 32'd0 || wren !== 1'b0 || ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL midop_reset: busy=%b pending=%h wren=%b ld_ready=%b, want 0 0 0 1",
               busy, pending, wren, ld_ready);
    end
    idle();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (wren !== 1'b0 || busy !== 1'b0 || pending !== 32'd0) begin
        errors++;
        $display("FAIL midop_stale[%0d]: wren=%b busy=%b pending=%h, want 0 0 0", i, wren, busy, pending);
      end
    end
  endtask

  task automatic test_random();
    int cand[$];
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc < 700) begin
        alu_valid = ($urandom_range(0, 99) < 40);
        alu_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        alu_data  = $urandom();
        iss_valid = ($urandom_range(0, 99) < 35);
        iss_rd    = 5'($urandom_range(0, 7));
        cand.delete();
        for (int r = 1; r < 32; r++) if (m_unsent[r] > 0) cand.push_back(r);
        ld_data = $urandom();
        if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
          ld_valid = 1'b1;
          ld_rd    = 5'(cand[$urandom_range(0, cand.size() - 1)]);
        end else if ($urandom_range(0, 19) == 0) begin
          ld_valid = 1'b1;
          ld_rd    = 5'd0;
        end else begin
          ld_valid = 1'b0;
          ld_rd    = 5'($urandom_range(0, 31));
        end
      end else begin
        idle();
      end
      step();
      checks++;
      if (wren !== m_wren || wr !== m_wr || wd !== m_wd) begin
        errors++;
        $display("FAIL rand_write[%0d]: wren=%b wr=%0d wd=%h, want %b %0d %h",
                 cyc, wren, wr, wd, m_wren, m_wr, m_wd);
      end
      checks++;
      if (pending !== model_pending() || busy !== (m_q.size() != 0) ||
          ld_ready !== (m_q.size() < DEPTH) || iss_ready !== model_iss_ready()) begin
        errors++;
        $display("FAIL rand_status[%0d]: pending=%h busy=%b ld_ready=%b iss_ready=%b, want %h %b %b %b",
                 cyc, pending, busy, ld_ready, iss_ready, model_pending(),
                 (m_q.size() != 0), (m_q.size() < DEPTH), model_iss_ready());
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_pending();
    test_back_to_back();
    test_zero_rd();
    test_saturation();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
